// File: rtl/singcyc_data_bus.sv
// singcyc_data_bus: data RAM plus timer/LED/switch/7-seg page with combinational read
module singcyc_data_bus #(
    parameter int          RAM_WORDS   = 256,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLed,
    output logic [11:0] oDigi,
    output logic        oIrq
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] th_q, th_d, tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d, sw1_q, sw1_d, sw2_q, sw2_d;
    logic [11:0] digi_q, digi_d;
    logic [29:0] rel_w;
    logic [2:0]  reg_sel;
    logic [AW-1:0] widx;
    logic        is_ram, is_per, we_per, ovf, irq_set;
    always_comb begin
        rel_w   = iAddr[31:2] - PERIPH_BASE[31:2];
        reg_sel = rel_w[2:0];
        widx    = iAddr[AW+1:2];
        is_ram  = iAddr < RAM_BYTES;
        is_per  = (rel_w[29:3] == 27'd0) && (reg_sel < 3'd6);
        we_per  = iMemWrite && is_per;
        ovf     = tcon_q[0] && (&tl_q);
        irq_set = ovf && tcon_q[1];
        th_d    = (we_per && reg_sel == 3'd0) ? iWrData : th_q;
        // a bus write to TL beats both increment and reload
        tl_d    = (we_per && reg_sel == 3'd1) ? iWrData :
                  !tcon_q[0] ? tl_q : ovf ? th_q : tl_q + 32'd1;
        tcon_d  = (we_per && reg_sel == 3'd2) ? {iWrData[2] | irq_set, iWrData[1:0]} :
                  {tcon_q[2] | irq_set, tcon_q[1:0]};
        led_d   = (we_per && reg_sel == 3'd3) ? iWrData[7:0] : led_q;
        digi_d  = (we_per && reg_sel == 3'd5) ? iWrData[11:0] : digi_q;
        sw1_d   = iSwitch;
        sw2_d   = sw1_q;
        oRdData = !iMemRead ? 32'h0 :
                  is_ram ? ram_q[widx] :
                  !is_per ? 32'h0 :
                  reg_sel == 3'd0 ? th_q :
                  reg_sel == 3'd1 ? tl_q :
                  reg_sel == 3'd2 ? {29'h0, tcon_q} :
                  reg_sel == 3'd3 ? {24'h0, led_q} :
                  reg_sel == 3'd4 ? {24'h0, sw2_q} :
                  {20'h0, digi_q};
    end
    always_ff @(posedge iClk) begin
        if (iRst) begin
            th_q   <= 32'h0;
            tl_q   <= 32'h0;
            tcon_q <= 3'h0;
            led_q  <= 8'h0;
            digi_q <= 12'h0;
            sw1_q  <= 8'h0;
            sw2_q  <= 8'h0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
            sw1_q  <= sw1_d;
            sw2_q  <= sw2_d;
        end
    end
    // RAM keeps its contents through reset, but writes are dropped while reset is held
    always_ff @(posedge iClk) begin
        if (!iRst && iMemWrite && is_ram) ram_q[widx] <= iWrData;
    end
    assign oLed  = led_q;
    assign oDigi = digi_q;
    assign oIrq  = tcon_q[2];
endmodule

// File: tb/tb_singcyc_data_bus.sv
// tb_singcyc_data_bus: directed vectors against hand-computed expectations
module tb_singcyc_data_bus;
    localparam logic [31:0] PB   = 32'h4000_0000;
    localparam logic [31:0] A_TH = PB + 32'h00;
    localparam logic [31:0] A_TL = PB + 32'h04;
    localparam logic [31:0] A_TC = PB + 32'h08;
    localparam logic [31:0] A_LD = PB + 32'h0C;
    localparam logic [31:0] A_SW = PB + 32'h10;
    localparam logic [31:0] A_DG = PB + 32'h14;
    logic        iClk = 1'b0, iRst, iMemRead, iMemWrite;
    logic [31:0] iAddr, iWrData, oRdData;
    logic [7:0]  iSwitch, oLed;
    logic [11:0] oDigi;
    logic        oIrq;
    logic [31:0] d;
    int checks = 0, errors = 0;

    singcyc_data_bus dut (
        .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iMemRead(iMemRead),
        .iMemWrite(iMemWrite), .iWrData(iWrData), .oRdData(oRdData),
        .iSwitch(iSwitch), .oLed(oLed), .oDigi(oDigi), .oIrq(oIrq)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        iAddr = a; iWrData = v; iMemWrite = 1'b1; iMemRead = 1'b0;
        cyc(1);
        iMemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        iAddr = a; iMemRead = 1'b1;
        #1;
        v = oRdData;
        iMemRead = 1'b0;
    endtask

    initial begin
        iRst = 1'b1; iMemRead = 1'b0; iMemWrite = 1'b0;
        iAddr = 32'h0; iWrData = 32'h0; iSwitch = 8'h0;
        cyc(2);
        iRst = 1'b0;
        check("rst_led", {24'h0, oLed}, 32'h0);
        check("rst_irq", {31'h0, oIrq}, 32'h0);
        rd(A_TL, d); check("rst_tl", d, 32'h0);
        // RAM
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, d); check("ram_rd", d, 32'hDEAD_BEEF);
        rd(32'h12, d); check("ram_rd_unaligned", d, 32'hDEAD_BEEF);
        wr(32'h14, 32'h0000_AAAA);
        iAddr = 32'h14; iWrData = 32'h0000_5555; iMemWrite = 1'b1; iMemRead = 1'b1;
        #1;
        check("ram_rdw_old", oRdData, 32'h0000_AAAA);
        cyc(1);
        iMemWrite = 1'b0; iMemRead = 1'b0;
        rd(32'h14, d); check("ram_rdw_new", d, 32'h0000_5555);
        // unmapped and no-read
        wr(32'h2000_0000, 32'h1234_5678);
        rd(32'h2000_0000, d); check("unmapped_rd", d, 32'h0);
        rd(PB + 32'h18, d); check("past_page_rd", d, 32'h0);
        iAddr = 32'h10; iMemRead = 1'b0;
        #1;
        check("no_read_zero", oRdData, 32'h0);
        // peripherals
        wr(A_LD, 32'h1A5);
        check("led_out", {24'h0, oLed}, 32'hA5);
        rd(A_LD, d); check("led_rd", d, 32'hA5);
        wr(A_DG, 32'hFFF3);
        check("digi_out", {20'h0, oDigi}, 32'hFF3);
        iSwitch = 8'h5C;
        cyc(1);
        rd(A_SW, d); check("sw_lat1", d, 32'h0);
        cyc(1);
        rd(A_SW, d); check("sw_lat2", d, 32'h5C);
        wr(A_SW, 32'hFF);
        rd(A_SW, d); check("sw_ro", d, 32'h5C);
        // timer reload
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TC, 32'h3);
        rd(A_TL, d); check("tmr_start", d, 32'hFFFF_FFFD);
        cyc(2);
        rd(A_TL, d); check("tmr_max", d, 32'hFFFF_FFFF);
        check("tmr_irq_pre", {31'h0, oIrq}, 32'h0);
        cyc(1);
        rd(A_TL, d); check("tmr_reload", d, 32'hFFFF_FFFD);
        check("tmr_irq", {31'h0, oIrq}, 32'h1);
        // overflow set beats software clear
        cyc(2);
        rd(A_TL, d); check("tmr_max2", d, 32'hFFFF_FFFF);
        wr(A_TC, 32'h3);
        rd(A_TC, d); check("tcon_hw_wins", d, 32'h7);
        check("irq_held", {31'h0, oIrq}, 32'h1);
        wr(A_TC, 32'h3);
        rd(A_TC, d); check("tcon_cleared", d, 32'h3);
        check("irq_cleared", {31'h0, oIrq}, 32'h0);
        // bus write to TL beats increment
        wr(A_TL, 32'h1234);
        rd(A_TL, d); check("tl_wr_wins", d, 32'h1234);
        cyc(1);
        rd(A_TL, d); check("tl_inc", d, 32'h1235);
        // reset mid-count with a concurrent write
        iRst = 1'b1; iAddr = A_LD; iWrData = 32'hFF; iMemWrite = 1'b1;
        cyc(1);
        iRst = 1'b0; iMemWrite = 1'b0;
        rd(A_TL, d); check("rst_mid_tl", d, 32'h0);
        rd(A_TC, d); check("rst_mid_tcon", d, 32'h0);
        check("rst_mid_led", {24'h0, oLed}, 32'h0);
        check("rst_mid_digi", {20'h0, oDigi}, 32'h0);
        check("rst_mid_irq", {31'h0, oIrq}, 32'h0);
        rd(32'h10, d); check("rst_ram_kept", d, 32'hDEAD_BEEF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
